fifo_burst_reader: RTL and testbench

//  Read-side sequencer for the async sample FIFO. On start_i it pops len_i samples through the

---
 rtl/fifo_pkg.sv | 15 +
 rtl/stream_buf2.sv | 48 ++++
 rtl/fifo_burst_reader.sv | 105 ++++++++++
 tb/tb_fifo_burst_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side burst sequencer.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_LEN_WIDTH  = 9;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StDrain = 3'd2,
    StFlush = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready buffer with synchronous flush; write and read may coincide.
module stream_buf2 #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             wr_en, rd_en;

  assign rd_valid_o = (cnt_q != 2'd0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign occ_o      = cnt_q;
  assign rd_en      = rd_valid_o & rd_ready_i;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign wr_en      = wr_valid_i & ((cnt_q != 2'd2) | rd_en);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(wr_en) - 2'(rd_en);
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a burst of samples from the async FIFO read port and streams them out with a last flag.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  abort_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_inc_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, issued_q, issued_inc;
  logic                  inflight_q, inflight_last_q;
  logic                  buf_valid, buf_flush, deq, last_tag, abort_hit;
  logic [DATA_WIDTH:0]   buf_data;
  logic [1:0]            occ;
  logic [2:0]            pending;

  assign deq        = buf_valid & m_ready_i;
  // Words already committed to the buffer once this cycle's handshake retires.
  assign pending    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
  assign issued_inc = issued_q + LEN_WIDTH'(1);
  assign last_tag   = (issued_inc == len_q);
  assign abort_hit  = abort_i & ((state_q == StRead) | (state_q == StDrain));
  assign buf_flush  = abort_hit | (state_q == StFlush);

  assign fifo_inc_o = (state_q == StRead) & ~fifo_empty_i & (issued_q < len_q) & ~abort_i &
                      (pending < 3'd2);

  assign m_valid_o = buf_valid;
  assign m_last_o  = buf_data[DATA_WIDTH];
  assign m_data_o  = buf_data[DATA_WIDTH-1:0];
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);

  stream_buf2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (buf_flush),
    .wr_valid_i (inflight_q),
    .wr_data_i  ({inflight_last_q, fifo_data_i}),
    .rd_ready_i (m_ready_i),
    .rd_valid_o (buf_valid),
    .rd_data_o  (buf_data),
    .occ_o      (occ)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (len_i == '0) ? StDone : StRead;
      end
      StRead: begin
        if (abort_i)                state_d = StFlush;
        else if (issued_q == len_q) state_d = StDrain;
      end
      StDrain: begin
        if (abort_i)                           state_d = StFlush;
        else if (!inflight_q && pending == '0) state_d = StDone;
      end
      StFlush: begin
        if (!inflight_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= StIdle;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= fifo_inc_o;
      inflight_last_q <= fifo_inc_o & last_tag;
      if (state_q == StIdle && start_i) begin
        len_q    <= len_i;
        issued_q <= '0;
      end else if (fifo_inc_o) begin
        issued_q <= issued_inc;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader against a queue-based FIFO/stream reference.
module tb_fifo_burst_reader;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, abort_i, fifo_empty_i, m_ready_i;
  logic [8:0] len_i;
  logic [7:0] fifo_data_i, m_data_o;
  logic       fifo_inc_o, m_valid_o, m_last_o, busy_o, done_o;

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(9)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .abort_i      (abort_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_inc_o   (fifo_inc_o),
    .fifo_data_i  (fifo_data_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_last_o     (m_last_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors, miscompares;
  logic [7:0] src_q[$];
  logic [8:0] out_q[$];
  int cyc, pop_cnt, done_cnt, first_pop_cyc, last_pop_cyc, first_valid_cyc, last_deq_cyc;
  int done_cyc, stall_viol, over_viol, empty_pop_viol, pend, rdy_mode;
  bit chk_pend;

  // Observes at the falling edge; the source FIFO model serves a pop just after the rising edge.
  initial begin : monitor
    logic inc_s, stall_s, abort_s;
    logic [8:0] held;
    stall_s = 1'b0; abort_s = 1'b0; held = '0; inc_s = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      inc_s = fifo_inc_o;
      if (rst_i) begin
        if (stall_s && !abort_s && (!m_valid_o || {m_last_o, m_data_o} !== held)) stall_viol++;
        if (inc_s) begin
          pop_cnt++;
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          if (fifo_empty_i) empty_pop_viol++;
        end
        if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid_o && m_ready_i) begin
          out_q.push_back({m_last_o, m_data_o});
          last_deq_cyc = cyc;
        end
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        pend = pend + int'(inc_s) - int'(m_valid_o && m_ready_i);
        if (chk_pend && pend > 2) over_viol++;
        stall_s = m_valid_o && !m_ready_i;
        held    = {m_last_o, m_data_o};
        abort_s = abort_i;
      end else begin
        stall_s = 1'b0;
      end
      @(posedge clk_i);
      #1;
      if (inc_s && rst_i && src_q.size() > 0) fifo_data_i = src_q.pop_front();
      fifo_empty_i = (src_q.size() == 0);
    end
  end

  initial begin : ready_drv
    m_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      case (rdy_mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ~m_ready_i;
        2:       m_ready_i = 1'($urandom_range(0, 1));
        default: m_ready_i = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clr_stats();
    out_q.delete();
    pop_cnt = 0; done_cnt = 0; first_pop_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
    last_deq_cyc = -1; done_cyc = -1; stall_viol = 0; over_viol = 0; empty_pop_viol = 0;
    pend = 0; chk_pend = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
    fifo_empty_i = (src_q.size() == 0);
  endtask

  task automatic start_burst(input int len, output int sc);
    start_i = 1'b1;
    len_i   = 9'(len);
    sc      = cyc + 1;
    tick();
    start_i = 1'b0;
    len_i   = 9'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > 0) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick();
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    vectors++; if (m_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", m_valid_o); end
    vectors++; if (fifo_inc_o !== 1'b0) begin miscompares++; $display("FAIL rst_inc: got %b want 0", fifo_inc_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done_o); end
    vectors++; if ({m_last_o, m_data_o} !== 9'h0) begin miscompares++; $display("FAIL rst_data: got %h want 000", {m_last_o, m_data_o}); end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int sc; bit tmo; logic [8:0] exp[$];
    src_q.delete(); fill(10); rdy_mode = 0; tick(); clr_stats();
    for (int i = 0; i < 4; i++) exp.push_back({(i == 3), src_q[i]});
    start_burst(4, sc);
    wait_done(40, tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL basic_timeout: got no done want done"); end
    vectors++; if (pop_cnt != 4) begin miscompares++; $display("FAIL basic_pops: got %0d want 4", pop_cnt); end
    vectors++; if (first_pop_cyc != sc + 1) begin miscompares++; $display("FAIL basic_first_pop: got %0d want %0d", first_pop_cyc - sc, 1); end
    vectors++; if (last_pop_cyc - first_pop_cyc != 3) begin miscompares++; $display("FAIL basic_pop_span: got %0d want 3", last_pop_cyc - first_pop_cyc); end
    vectors++; if (first_valid_cyc - first_pop_cyc != 2) begin miscompares++; $display("FAIL basic_latency: got %0d want 2", first_valid_cyc - first_pop_cyc); end
    vectors++; if (done_cyc - last_deq_cyc != 1) begin miscompares++; $display("FAIL basic_done_gap: got %0d want 1", done_cyc - last_deq_cyc); end
    vectors++; if (out_q.size() != 4) begin miscompares++; $display("FAIL basic_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp[i]) begin miscompares++; $display("FAIL basic_word%0d: got %h want %h", i, out_q[i], exp[i]); end
    end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_stall();
    int sc; bit tmo; logic [8:0] exp[$];
    src_q.delete(); fill(12); rdy_mode = 1; tick(); clr_stats();
    for (int i = 0; i < 8; i++) exp.push_back({(i == 7), src_q[i]});
    start_burst(8, sc);
    wait_done(80, tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL stall_timeout: got no done want done"); end
    vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
    vectors++; if (over_viol != 0) begin miscompares++; $display("FAIL stall_occupancy: got %0d overflows want 0", over_viol); end
    vectors++; if (out_q.size() != 8) begin miscompares++; $display("FAIL stall_count: got %0d want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp[i]) begin miscompares++; $display("FAIL stall_word%0d: got %h want %h", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_empty_gap();
    int sc; bit tmo; logic [8:0] exp[$];
    src_q.delete(); fill(3); rdy_mode = 0; tick(); clr_stats();
    for (int i = 0; i < 3; i++) exp.push_back({1'b0, src_q[i]});
    start_burst(6, sc);
    repeat (20) tick();
    vectors++; if (pop_cnt != 3) begin miscompares++; $display("FAIL gap_pops: got %0d want 3", pop_cnt); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL gap_busy: got %b want 1", busy_o); end
    vectors++; if (empty_pop_viol != 0) begin miscompares++; $display("FAIL gap_empty_pop: got %0d want 0", empty_pop_viol); end
    fill(3);
    for (int i = 0; i < 3; i++) exp.push_back({(i == 2), src_q[i]});
    wait_done(40, tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL gap_timeout: got no done want done"); end
    vectors++; if (out_q.size() != 6) begin miscompares++; $display("FAIL gap_count: got %0d want 6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp[i]) begin miscompares++; $display("FAIL gap_word%0d: got %h want %h", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_zero_len();
    int sc; bit tmo;
    src_q.delete(); fill(4); rdy_mode = 0; tick(); clr_stats();
    start_burst(0, sc);
    wait_done(10, tmo);
    repeat (2) tick();
    vectors++; if (tmo || done_cyc - sc < 1 || done_cyc - sc > 2) begin miscompares++; $display("FAIL zero_done_delay: got %0d want 1..2", done_cyc - sc); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    vectors++; if (pop_cnt != 0) begin miscompares++; $display("FAIL zero_pops: got %0d want 0", pop_cnt); end
    vectors++; if (first_valid_cyc != -1) begin miscompares++; $display("FAIL zero_valid: got cycle %0d want none", first_valid_cyc - sc); end
  endtask

  task automatic test_abort();
    int sc, ac, k; bit tmo; logic [8:0] exp[$];
    src_q.delete(); fill(10); rdy_mode = 3; tick(); clr_stats();
    start_burst(8, sc);
    k = 0;
    while (pop_cnt < 2 && k < 20) begin tick(); k++; end
    vectors++; if (pop_cnt < 2) begin miscompares++; $display("FAIL abort_prepops: got %0d want 2", pop_cnt); end
    abort_i = 1'b1; ac = cyc + 1;
    tick();
    abort_i = 1'b0;
    vectors++; if (m_valid_o !== 1'b0) begin miscompares++; $display("FAIL abort_valid_drop: got %b want 0", m_valid_o); end
    wait_done(10, tmo);
    vectors++; if (tmo || done_cyc - ac < 1 || done_cyc - ac > 3) begin miscompares++; $display("FAIL abort_done_delay: got %0d want 1..3", done_cyc - ac); end
    vectors++; if (pop_cnt != 2) begin miscompares++; $display("FAIL abort_pops: got %0d want 2", pop_cnt); end
    vectors++; if (out_q.size() != 0) begin miscompares++; $display("FAIL abort_leak: got %0d words want 0", out_q.size()); end
    rdy_mode = 0; tick(); clr_stats();
    for (int i = 0; i < 2; i++) exp.push_back({(i == 1), src_q[i]});
    start_burst(2, sc);
    wait_done(30, tmo);
    vectors++; if (tmo || out_q.size() != 2) begin miscompares++; $display("FAIL abort_restart_count: got %0d want 2", out_q.size()); end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp[i]) begin miscompares++; $display("FAIL abort_restart_word%0d: got %h want %h", i, out_q[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    int sc, len; bit tmo; logic [8:0] exp[$];
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, 12);
      rdy_mode = $urandom_range(0, 2);
      src_q.delete(); fill(len + $urandom_range(0, 3)); tick(); clr_stats();
      exp.delete();
      for (int i = 0; i < len; i++) exp.push_back({(i == len - 1), src_q[i]});
      start_burst(len, sc);
      wait_done(200, tmo);
      vectors++; if (tmo || out_q.size() != len) begin miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", b, out_q.size(), len); end
      vectors++; if (over_viol != 0 || stall_viol != 0) begin miscompares++; $display("FAIL rand%0d_flow: got %0d/%0d want 0/0", b, over_viol, stall_viol); end
      for (int i = 0; i < len && i < out_q.size(); i++) begin
        vectors++; if (out_q[i] !== exp[i]) begin miscompares++; $display("FAIL rand%0d_word%0d: got %h want %h", b, i, out_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    int sc; bit tmo; logic [8:0] exp[$];
    src_q.delete(); fill(30); rdy_mode = 2; tick(); clr_stats();
    start_burst(20, sc);
    repeat (6) tick();
    rst_i = 1'b0;
    #1;
    vectors++; if ({busy_o, m_valid_o, fifo_inc_o, done_o, m_last_o} !== 5'b0) begin miscompares++; $display("FAIL arst_ctrl: got %b want 00000", {busy_o, m_valid_o, fifo_inc_o, done_o, m_last_o}); end
    vectors++; if (m_data_o !== 8'h0) begin miscompares++; $display("FAIL arst_data: got %h want 00", m_data_o); end
    tick(); tick();
    rst_i = 1'b1;
    rdy_mode = 0; tick(); clr_stats();
    for (int i = 0; i < 3; i++) exp.push_back({(i == 2), src_q[i]});
    start_burst(3, sc);
    wait_done(30, tmo);
    vectors++; if (tmo || out_q.size() != 3) begin miscompares++; $display("FAIL arst_restart_count: got %0d want 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      vectors++; if (out_q[i] !== exp[i]) begin miscompares++; $display("FAIL arst_restart_word%0d: got %h want %h", i, out_q[i], exp[i]); end
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0;
    fifo_data_i = '0; fifo_empty_i = 1'b1; rdy_mode = 0;
    vectors = 0; miscompares = 0; pend = 0; chk_pend = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_empty_gap();
    test_zero_len();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
